ccl_loop_issuer: RTL and testbench

//  Initiator side of the CCLU loop-stack interface. Accepts loop instructions (LOOP/BREAK) from the

---
 rtl/ccl_loop_issuer_if.sv | 58 +++++
 rtl/ccl_loop_issuer.sv | 268 ++++++++++++++++++++++++++
 tb/tb_ccl_loop_issuer.sv | 309 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ccl_loop_issuer_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// ccl_loop_issuer_if : fetch-side and CCLU-side port bundles   | rev 1.0
// ----------------------------------------------------------------------------

interface ccl_ins_if #(
  parameter int WIDTH = 32
);
  logic             valid;
  logic             ready;
  logic [1:0]       op;
  logic [WIDTH-1:0] address;
  logic [WIDTH-1:0] counter;
  logic [WIDTH-1:0] target;
  logic             flush;
  logic             rsp_valid;
  logic             rsp_taken;
  logic [WIDTH-1:0] rsp_target;
  logic             rsp_error;
  logic             rsp_full;
  logic             rsp_mismatch;

  modport master (
    output valid, op, address, counter, target, flush,
    input  ready, rsp_valid, rsp_taken, rsp_target, rsp_error, rsp_full, rsp_mismatch
  );

  modport slave (
    input  valid, op, address, counter, target, flush,
    output ready, rsp_valid, rsp_taken, rsp_target, rsp_error, rsp_full, rsp_mismatch
  );
endinterface

interface ccl_cclu_if #(
  parameter int WIDTH = 32
);
  logic [1:0]       command;
  logic [WIDTH-1:0] address;
  logic [WIDTH-1:0] counter;
  logic [WIDTH-1:0] target;
  logic             reset;
  logic [WIDTH-1:0] out_target;
  logic             valid;
  logic             full;
  logic             error;

  modport master (
    output command, address, counter, target, reset,
    input  out_target, valid, full, error
  );

  modport slave (
    input  command, address, counter, target, reset,
    output out_target, valid, full, error
  );
endinterface

`default_nettype wire

// File: rtl/ccl_loop_issuer.sv
`default_nettype none
// ----------------------------------------------------------------------------
// ccl_loop_issuer : CCLU loop-stack initiator with shadow full/error predictor
// rev 1.0
// ----------------------------------------------------------------------------

module ccl_loop_issuer #(
  parameter int DEPTH    = 16,
  parameter int WIDTH    = 32,
  parameter int RESP_LAT = 1
) (
  input  logic                   clock,
  input  logic                   reset,
  ccl_ins_if.slave               ins,
  ccl_cclu_if.master             cclu,
  output logic [$clog2(DEPTH):0] depth
);

  localparam int SLOTS = DEPTH - 1;
  localparam int DW    = $clog2(DEPTH) + 1;
  localparam int IW    = (SLOTS > 1) ? $clog2(SLOTS) : 1;
  localparam int LATW  = (RESP_LAT > 1) ? $clog2(RESP_LAT) : 1;

  localparam logic [1:0] OP_NOP   = 2'b00;
  localparam logic [1:0] OP_LOOP  = 2'b01;
  localparam logic [1:0] OP_BREAK = 2'b10;

  typedef enum logic [2:0] {
    S_CLEAR = 3'd0,
    S_IDLE  = 3'd1,
    S_ISSUE = 3'd2,
    S_WAIT  = 3'd3,
    S_RESP  = 3'd4
  } state_t;

  typedef enum logic [1:0] {
    ACT_NONE = 2'd0,
    ACT_PUSH = 2'd1,
    ACT_POP  = 2'd2,
    ACT_DEC  = 2'd3
  } act_t;

  state_t            state_q, state_d;
  logic              ready_q, ready_d;
  logic [1:0]        cmd_q, cmd_d;
  logic              creset_q, creset_d;
  logic              flush_q, flush_d;
  logic [1:0]        cap_op_q, cap_op_d;
  logic [WIDTH-1:0]  cap_addr_q, cap_addr_d;
  logic [WIDTH-1:0]  cap_cnt_q, cap_cnt_d;
  logic [WIDTH-1:0]  cap_tgt_q, cap_tgt_d;
  act_t              act_q, act_d;
  logic [2:0]        exp_q, exp_d;
  logic [LATW-1:0]   wait_q, wait_d;
  logic [DW-1:0]     depth_q, depth_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic              rsp_taken_q, rsp_taken_d;
  logic [WIDTH-1:0]  rsp_target_q, rsp_target_d;
  logic              rsp_error_q, rsp_error_d;
  logic              rsp_full_q, rsp_full_d;
  logic              rsp_mismatch_q, rsp_mismatch_d;
  logic [WIDTH-1:0]  addr_q [SLOTS];
  logic [WIDTH-1:0]  addr_d [SLOTS];
  logic [WIDTH-1:0]  cnt_q  [SLOTS];
  logic [WIDTH-1:0]  cnt_d  [SLOTS];

  logic [IW-1:0]     top_idx;
  logic [IW-1:0]     push_idx;
  logic              top_hit;
  act_t              p_act;
  logic [2:0]        p_exp;
  logic              p_full;

  // Prediction is taken on the offered instruction; the shadow stack cannot
  // change between accept and ISSUE, so the result is stored and replayed.
  always_comb begin
    top_idx  = IW'(depth_q - DW'(1));
    push_idx = IW'(depth_q);
    top_hit  = (depth_q != '0) && (ins.address == addr_q[top_idx]);
    p_act    = ACT_NONE;
    p_exp    = 3'b000;
    p_full   = 1'b0;
    case (ins.op)
      OP_LOOP: begin
        if (top_hit) begin
          p_exp = 3'b100;
          p_act = (cnt_q[top_idx] == WIDTH'(1)) ? ACT_POP : ACT_DEC;
        end else if (ins.counter == '0) begin
          p_exp = 3'b010;
        end else if (ins.counter == WIDTH'(1)) begin
          p_exp = 3'b100;
        end else if (depth_q == DW'(SLOTS)) begin
          p_full = 1'b1;
        end else begin
          p_exp = 3'b100;
          p_act = ACT_PUSH;
        end
      end
      OP_BREAK: begin
        if (depth_q == '0) begin
          p_exp = 3'b010;
        end else begin
          p_exp = 3'b000;
          p_act = ACT_POP;
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d        = state_q;
    cap_op_d       = cap_op_q;
    cap_addr_d     = cap_addr_q;
    cap_cnt_d      = cap_cnt_q;
    cap_tgt_d      = cap_tgt_q;
    act_d          = act_q;
    exp_d          = exp_q;
    wait_d         = wait_q;
    depth_d        = depth_q;
    addr_d         = addr_q;
    cnt_d          = cnt_q;
    rsp_valid_d    = 1'b0;
    rsp_taken_d    = 1'b0;
    rsp_target_d   = '0;
    rsp_error_d    = 1'b0;
    rsp_full_d     = 1'b0;
    rsp_mismatch_d = 1'b0;

    case (state_q)
      // After reset cclu_reset is still low, so CLEAR holds one extra cycle
      // to give the CCLU a full reset cycle before the first accept.
      S_CLEAR: begin
        if (creset_q) state_d = S_IDLE;
      end
      S_IDLE: begin
        if (flush_q) begin
          state_d = S_CLEAR;
        end else if (ins.valid && ready_q) begin
          if (ins.op == 2'b11) begin
            state_d     = S_RESP;
            rsp_valid_d = 1'b1;
            rsp_error_d = 1'b1;
          end else if (ins.op != OP_NOP) begin
            if (p_full) begin
              state_d     = S_RESP;
              rsp_valid_d = 1'b1;
              rsp_full_d  = 1'b1;
            end else begin
              state_d    = S_ISSUE;
              cap_op_d   = ins.op;
              cap_addr_d = ins.address;
              cap_cnt_d  = ins.counter;
              cap_tgt_d  = ins.target;
              act_d      = p_act;
              exp_d      = p_exp;
            end
          end
        end
      end
      S_ISSUE: begin
        state_d = S_WAIT;
        wait_d  = LATW'(RESP_LAT - 1);
        case (act_q)
          ACT_PUSH: begin
            addr_d[push_idx] = cap_addr_q;
            cnt_d[push_idx]  = cap_cnt_q - WIDTH'(1);
            depth_d          = depth_q + DW'(1);
          end
          ACT_POP: depth_d = depth_q - DW'(1);
          ACT_DEC: cnt_d[top_idx] = cnt_q[top_idx] - WIDTH'(1);
          default: ;
        endcase
      end
      S_WAIT: begin
        if (wait_q == '0) begin
          state_d        = S_RESP;
          rsp_valid_d    = 1'b1;
          rsp_taken_d    = cclu.valid;
          rsp_target_d   = cclu.out_target;
          rsp_error_d    = cclu.error;
          rsp_full_d     = cclu.full;
          rsp_mismatch_d = ({cclu.valid, cclu.error, cclu.full} != exp_q);
        end else begin
          wait_d = wait_q - LATW'(1);
        end
      end
      S_RESP: begin
        state_d = flush_q ? S_CLEAR : S_IDLE;
      end
      default: state_d = S_CLEAR;
    endcase

    // Registered outputs are decoded from the state being entered.
    flush_d  = (state_d == S_CLEAR) ? 1'b0 : (flush_q | ins.flush);
    creset_d = (state_d == S_CLEAR);
    ready_d  = (state_d == S_IDLE) && !flush_d;
    cmd_d    = (state_d == S_ISSUE) ? cap_op_d : OP_NOP;
    if (state_d == S_CLEAR) depth_d = '0;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q        <= S_CLEAR;
      ready_q        <= 1'b0;
      cmd_q          <= OP_NOP;
      creset_q       <= 1'b0;
      flush_q        <= 1'b0;
      cap_op_q       <= OP_NOP;
      cap_addr_q     <= '0;
      cap_cnt_q      <= '0;
      cap_tgt_q      <= '0;
      act_q          <= ACT_NONE;
      exp_q          <= 3'b000;
      wait_q         <= '0;
      depth_q        <= '0;
      rsp_valid_q    <= 1'b0;
      rsp_taken_q    <= 1'b0;
      rsp_target_q   <= '0;
      rsp_error_q    <= 1'b0;
      rsp_full_q     <= 1'b0;
      rsp_mismatch_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      ready_q        <= ready_d;
      cmd_q          <= cmd_d;
      creset_q       <= creset_d;
      flush_q        <= flush_d;
      cap_op_q       <= cap_op_d;
      cap_addr_q     <= cap_addr_d;
      cap_cnt_q      <= cap_cnt_d;
      cap_tgt_q      <= cap_tgt_d;
      act_q          <= act_d;
      exp_q          <= exp_d;
      wait_q         <= wait_d;
      depth_q        <= depth_d;
      rsp_valid_q    <= rsp_valid_d;
      rsp_taken_q    <= rsp_taken_d;
      rsp_target_q   <= rsp_target_d;
      rsp_error_q    <= rsp_error_d;
      rsp_full_q     <= rsp_full_d;
      rsp_mismatch_q <= rsp_mismatch_d;
    end
  end

  // Stack payload is only meaningful below depth_q, so it carries no reset.
  always_ff @(posedge clock) begin
    addr_q <= addr_d;
    cnt_q  <= cnt_d;
  end

  assign ins.ready        = ready_q;
  assign ins.rsp_valid    = rsp_valid_q;
  assign ins.rsp_taken    = rsp_taken_q;
  assign ins.rsp_target   = rsp_target_q;
  assign ins.rsp_error    = rsp_error_q;
  assign ins.rsp_full     = rsp_full_q;
  assign ins.rsp_mismatch = rsp_mismatch_q;
  assign cclu.command     = cmd_q;
  assign cclu.address     = cap_addr_q;
  assign cclu.counter     = cap_cnt_q;
  assign cclu.target      = cap_tgt_q;
  assign cclu.reset       = creset_q;
  assign depth            = depth_q;

endmodule

`default_nettype wire

// File: tb/tb_ccl_loop_issuer.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_ccl_loop_issuer : directed self-checking bench for ccl_loop_issuer | rev 1.0
// ----------------------------------------------------------------------------

module tb_ccl_loop_issuer;

  localparam int WIDTH    = 32;
  localparam int DEPTH    = 16;
  localparam int RESP_LAT = 1;

  logic clock;
  logic reset;
  logic [$clog2(DEPTH):0] depth;

  ccl_ins_if  #(.WIDTH(WIDTH)) ins_bus ();
  ccl_cclu_if #(.WIDTH(WIDTH)) cclu_bus ();

  ccl_loop_issuer #(
    .DEPTH    (DEPTH),
    .WIDTH    (WIDTH),
    .RESP_LAT (RESP_LAT)
  ) dut (
    .clock (clock),
    .reset (reset),
    .ins   (ins_bus),
    .cclu  (cclu_bus),
    .depth (depth)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_cmp = 0;
  int n_bad = 0;
  int n_loop_cmd = 0;
  int n_brk_cmd = 0;

  // Planned CCLU answer for the next command
  logic             plan_v, plan_e, plan_f;
  logic [WIDTH-1:0] plan_t;

  always @(posedge clock or negedge reset) begin
    if (!reset) begin
      cclu_bus.valid      <= 1'b0;
      cclu_bus.error      <= 1'b0;
      cclu_bus.full       <= 1'b0;
      cclu_bus.out_target <= '0;
    end else if (cclu_bus.command != 2'b00) begin
      cclu_bus.valid      <= plan_v;
      cclu_bus.error      <= plan_e;
      cclu_bus.full       <= plan_f;
      cclu_bus.out_target <= plan_t;
    end else begin
      cclu_bus.valid      <= 1'b0;
      cclu_bus.error      <= 1'b0;
      cclu_bus.full       <= 1'b0;
      cclu_bus.out_target <= '0;
    end
  end

  always @(negedge clock) begin
    if (cclu_bus.command == 2'b01) n_loop_cmd++;
    if (cclu_bus.command == 2'b10) n_brk_cmd++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  logic             r_taken, r_error, r_full, r_mis;
  logic [WIDTH-1:0] r_tgt;
  int               r_lat;

  task automatic wait_ready();
    int k;
    k = 0;
    while (!ins_bus.ready && k < 50) begin
      @(negedge clock);
      k++;
    end
    chk("ready_wait", ins_bus.ready, 1);
  endtask

  task automatic send(input logic [1:0] op, input logic [WIDTH-1:0] a,
                      input logic [WIDTH-1:0] c, input logic [WIDTH-1:0] t);
    wait_ready();
    ins_bus.valid   = 1'b1;
    ins_bus.op      = op;
    ins_bus.address = a;
    ins_bus.counter = c;
    ins_bus.target  = t;
    @(negedge clock);
    ins_bus.valid = 1'b0;
    ins_bus.op    = 2'b00;
    r_lat = 1;
    while (!ins_bus.rsp_valid && r_lat < 20) begin
      @(negedge clock);
      r_lat++;
    end
    r_taken = ins_bus.rsp_taken;
    r_tgt   = ins_bus.rsp_target;
    r_error = ins_bus.rsp_error;
    r_full  = ins_bus.rsp_full;
    r_mis   = ins_bus.rsp_mismatch;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, n_cmp=%0d", n_cmp);
    $fatal(1, "watchdog");
  end

  initial begin
    int l0, b0, fill_ok;
    logic seen;

    reset            = 1'b0;
    ins_bus.valid    = 1'b0;
    ins_bus.op       = 2'b00;
    ins_bus.address  = '0;
    ins_bus.counter  = '0;
    ins_bus.target   = '0;
    ins_bus.flush    = 1'b0;
    plan_v = 1'b0; plan_e = 1'b0; plan_f = 1'b0; plan_t = '0;

    // Reset values
    repeat (3) @(negedge clock);
    chk("rst_cclu_reset", cclu_bus.reset, 0);
    chk("rst_command", cclu_bus.command, 0);
    chk("rst_ready", ins_bus.ready, 0);
    chk("rst_depth", depth, 0);
    chk("rst_rsp_valid", ins_bus.rsp_valid, 0);
    reset = 1'b1;
    @(negedge clock);
    chk("clr_cclu_reset", cclu_bus.reset, 1);
    chk("clr_command", cclu_bus.command, 0);
    chk("clr_ready", ins_bus.ready, 0);
    @(negedge clock);
    chk("idle_ready", ins_bus.ready, 1);
    chk("idle_cclu_reset", cclu_bus.reset, 0);
    chk("idle_depth", depth, 0);

    // LOOP 0x40 cnt 3 then continued twice: depth 1,1,0
    plan_v = 1'b1; plan_e = 1'b0; plan_f = 1'b0; plan_t = 32'h10;
    l0 = n_loop_cmd;
    send(2'b01, 32'h40, 32'd3, 32'h10);
    chk("l1_lat", r_lat, 3);
    chk("l1_taken", r_taken, 1);
    chk("l1_target", r_tgt, 32'h10);
    chk("l1_mis", r_mis, 0);
    chk("l1_depth", depth, 1);
    chk("l1_cmds", n_loop_cmd - l0, 1);
    @(negedge clock);
    chk("l1_rsp_pulse", ins_bus.rsp_valid, 0);
    send(2'b01, 32'h40, 32'd3, 32'h10);
    chk("l2_lat", r_lat, 3);
    chk("l2_taken", r_taken, 1);
    chk("l2_depth", depth, 1);
    send(2'b01, 32'h40, 32'd3, 32'h10);
    chk("l3_taken", r_taken, 1);
    chk("l3_target", r_tgt, 32'h10);
    chk("l3_depth", depth, 0);
    chk("l123_cmds", n_loop_cmd - l0, 3);

    // BREAK on empty stack
    plan_v = 1'b0; plan_e = 1'b1; plan_f = 1'b0; plan_t = '0;
    b0 = n_brk_cmd;
    send(2'b10, '0, '0, '0);
    chk("brk0_lat", r_lat, 3);
    chk("brk0_cmds", n_brk_cmd - b0, 1);
    chk("brk0_error", r_error, 1);
    chk("brk0_taken", r_taken, 0);
    chk("brk0_mis", r_mis, 0);
    chk("brk0_depth", depth, 0);

    // Illegal op answered locally
    l0 = n_loop_cmd; b0 = n_brk_cmd;
    send(2'b11, 32'h77, 32'd2, 32'h88);
    chk("ill_lat", r_lat, 1);
    chk("ill_error", r_error, 1);
    chk("ill_taken", r_taken, 0);
    chk("ill_mis", r_mis, 0);
    chk("ill_cmds", (n_loop_cmd - l0) + (n_brk_cmd - b0), 0);

    // NOP is dropped silently
    wait_ready();
    ins_bus.valid = 1'b1;
    ins_bus.op    = 2'b00;
    @(negedge clock);
    ins_bus.valid = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 4; k++) begin
      if (ins_bus.rsp_valid || cclu_bus.command != 2'b00) seen = 1'b1;
      @(negedge clock);
    end
    chk("nop_silent", seen, 0);
    chk("nop_ready", ins_bus.ready, 1);
    chk("nop_depth", depth, 0);

    // Fill the shadow stack to DEPTH-1
    plan_v = 1'b1; plan_e = 1'b0; plan_f = 1'b0;
    l0 = n_loop_cmd;
    fill_ok = 0;
    for (int i = 0; i < 15; i++) begin
      plan_t = 32'h20 + i;
      send(2'b01, 32'h100 + i, 32'd5, 32'h20 + i);
      if (r_taken && r_lat == 3 && !r_mis && r_tgt == 32'h20 + i) fill_ok++;
    end
    chk("fill_ok", fill_ok, 15);
    chk("fill_depth", depth, 15);
    chk("fill_cmds", n_loop_cmd - l0, 15);

    // 16th new LOOP refused locally
    l0 = n_loop_cmd;
    send(2'b01, 32'h200, 32'd5, 32'h99);
    chk("full_lat", r_lat, 1);
    chk("full_flag", r_full, 1);
    chk("full_error", r_error, 0);
    chk("full_taken", r_taken, 0);
    chk("full_cmds", n_loop_cmd - l0, 0);
    chk("full_depth", depth, 15);
    @(negedge clock);
    chk("full_pulse", ins_bus.rsp_valid, 0);

    // Continuing the top loop while full is still issued
    plan_t = 32'h2E;
    send(2'b01, 32'h10E, 32'd5, 32'h2E);
    chk("cont_lat", r_lat, 3);
    chk("cont_taken", r_taken, 1);
    chk("cont_target", r_tgt, 32'h2E);
    chk("cont_mis", r_mis, 0);
    chk("cont_depth", depth, 15);

    // Flush pulsed during WAIT of a BREAK
    plan_v = 1'b0; plan_e = 1'b0; plan_f = 1'b0; plan_t = '0;
    wait_ready();
    ins_bus.valid = 1'b1;
    ins_bus.op    = 2'b10;
    @(negedge clock);
    ins_bus.valid = 1'b0;
    ins_bus.op    = 2'b00;
    chk("fl_issue_cmd", cclu_bus.command, 2'b10);
    @(negedge clock);
    ins_bus.flush = 1'b1;
    @(negedge clock);
    ins_bus.flush = 1'b0;
    chk("fl_rsp_valid", ins_bus.rsp_valid, 1);
    chk("fl_rsp_mis", ins_bus.rsp_mismatch, 0);
    chk("fl_rsp_taken", ins_bus.rsp_taken, 0);
    chk("fl_depth_pop", depth, 14);
    @(negedge clock);
    chk("fl_cclu_reset", cclu_bus.reset, 1);
    chk("fl_command", cclu_bus.command, 0);
    chk("fl_ready", ins_bus.ready, 0);
    chk("fl_depth", depth, 0);
    @(negedge clock);
    chk("fl_ready_after", ins_bus.ready, 1);
    chk("fl_cclu_reset_after", cclu_bus.reset, 0);

    // CCLU disagrees with the shadow prediction
    plan_v = 1'b0; plan_e = 1'b0; plan_f = 1'b0; plan_t = 32'h50;
    send(2'b01, 32'h500, 32'd4, 32'h50);
    chk("mis_lat", r_lat, 3);
    chk("mis_flag", r_mis, 1);
    chk("mis_taken", r_taken, 0);
    chk("mis_depth", depth, 1);

    // Reset in the middle of an issue
    plan_v = 1'b1; plan_t = 32'h60;
    wait_ready();
    ins_bus.valid   = 1'b1;
    ins_bus.op      = 2'b01;
    ins_bus.address = 32'h600;
    ins_bus.counter = 32'd2;
    ins_bus.target  = 32'h60;
    @(negedge clock);
    ins_bus.valid = 1'b0;
    ins_bus.op    = 2'b00;
    chk("mr_pre_cmd", cclu_bus.command, 2'b01);
    chk("mr_pre_depth", depth, 1);
    reset = 1'b0;
    #1;
    chk("mr_cmd", cclu_bus.command, 0);
    chk("mr_depth", depth, 0);
    chk("mr_ready", ins_bus.ready, 0);
    chk("mr_cclu_reset", cclu_bus.reset, 0);
    @(negedge clock);
    @(negedge clock);
    chk("mr_no_rsp", ins_bus.rsp_valid, 0);
    reset = 1'b1;
    @(negedge clock);
    chk("mr_clr_cclu_reset", cclu_bus.reset, 1);
    chk("mr_clr_ready", ins_bus.ready, 0);
    @(negedge clock);
    chk("mr_idle_ready", ins_bus.ready, 1);
    chk("mr_idle_depth", depth, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
